// File: rtl/ac97_link_frame_pkg.sv
// Shared AC-link frame geometry: slot/tag/frame sizes, slot word type and the
// helper that locates a slot's first bit inside the 256-bit frame.
package ac97_pkg;

  localparam int AC97_SLOT_BITS  = 20;
  localparam int AC97_TAG_BITS   = 16;
  localparam int AC97_FRAME_BITS = 256;
  localparam int AC97_SYNC_LEN   = 16;

  typedef logic [AC97_SLOT_BITS-1:0] ac97_slot_t;

  // Frame bit index of the MSB of slot s (1-based); bit index == bit_q on the wire.
  function automatic int slot_start(input int s);
    return AC97_TAG_BITS + AC97_SLOT_BITS * (s - 1);
  endfunction

endpackage

// File: rtl/ac97_link_frame_if.sv
// Producer-side bus of the AC-link frame engine: transmit slots in, frame
// strobe and decoded codec input frame out.
interface ac97_link_frame_if #(parameter int NUM_OUT_SLOTS = 4);
  import ac97_pkg::*;

  logic                                    tx_en;
  logic [NUM_OUT_SLOTS*AC97_SLOT_BITS-1:0] tx_slot_data;
  logic [NUM_OUT_SLOTS-1:0]                tx_slot_valid;
  logic                                    ac97_strobe;
  logic                                    codec_ready;
  logic [6:0]                              status_addr;
  logic [15:0]                             status_data;
  logic                                    status_valid;
  logic [9:0]                              rx_slotreq;
  ac97_slot_t                              pcm_in_l;
  ac97_slot_t                              pcm_in_r;
  logic                                    pcm_in_valid;

  modport master (
    output tx_en, tx_slot_data, tx_slot_valid,
    input  ac97_strobe, codec_ready, status_addr, status_data, status_valid,
    input  rx_slotreq, pcm_in_l, pcm_in_r, pcm_in_valid
  );

  modport slave (
    input  tx_en, tx_slot_data, tx_slot_valid,
    output ac97_strobe, codec_ready, status_addr, status_data, status_valid,
    output rx_slotreq, pcm_in_l, pcm_in_r, pcm_in_valid
  );

endinterface

// File: rtl/ac97_link_frame_rx.sv
// Codec input-frame deframer: negedge pin sampler, 256-bit shift register and
// tag/slot decode at the start of the following frame (AC97_LINK_RX_EN builds only).
`ifdef AC97_LINK_RX_EN
module ac97_rx_deframer
  import ac97_pkg::*;
(
  input  logic       ac97_bitclk,
  input  logic       rst,
  input  logic [7:0] bit_q,
  input  logic       ac97_sdata_in,
  output logic       codec_ready,
  output logic [6:0] status_addr,
  output logic [15:0] status_data,
  output logic       status_valid,
  output logic [9:0] rx_slotreq,
  output ac97_slot_t pcm_in_l,
  output ac97_slot_t pcm_in_r,
  output logic       pcm_in_valid
);

  // First received bit ends up in the MSB, so wire position p sits at shift_r[TAG_HI-p].
  localparam int TAG_HI = AC97_FRAME_BITS - 1;
  localparam int S1_HI  = AC97_FRAME_BITS - 1 - slot_start(1);
  localparam int S2_HI  = AC97_FRAME_BITS - 1 - slot_start(2);
  localparam int S3_HI  = AC97_FRAME_BITS - 1 - slot_start(3);
  localparam int S4_HI  = AC97_FRAME_BITS - 1 - slot_start(4);

  logic                       rx_bit_r;
  logic [AC97_FRAME_BITS-1:0] shift_r;

  // Pin sampler: the codec launches on posedge, so mid-bit negedge is the safe point.
  always_ff @(negedge ac97_bitclk) begin
    rx_bit_r <= ac97_sdata_in;
  end

  // Shift in one bit per cycle; decode the completed frame on the bit 0 -> 1 edge.
  always_ff @(posedge ac97_bitclk) begin
    if (rst) begin
      shift_r      <= {AC97_FRAME_BITS{1'b0}};
      codec_ready  <= 1'b0;
      status_addr  <= 7'd0;
      status_data  <= 16'd0;
      status_valid <= 1'b0;
      rx_slotreq   <= 10'd0;
      pcm_in_l     <= 20'd0;
      pcm_in_r     <= 20'd0;
      pcm_in_valid <= 1'b0;
    end else begin
      shift_r <= {shift_r[AC97_FRAME_BITS-2:0], rx_bit_r};
      if (bit_q == 8'd0) begin
        codec_ready  <= shift_r[TAG_HI];
        rx_slotreq   <= shift_r[S1_HI-8 -: 10];
        status_valid <= shift_r[TAG_HI-1] & shift_r[TAG_HI-2];
        pcm_in_valid <= shift_r[TAG_HI-3] | shift_r[TAG_HI-4];
        if (shift_r[TAG_HI-1] & shift_r[TAG_HI-2]) begin
          status_addr <= shift_r[S1_HI-1 -: 7];
          status_data <= shift_r[S2_HI -: 16];
        end
        if (shift_r[TAG_HI-3]) begin
          pcm_in_l <= shift_r[S3_HI -: AC97_SLOT_BITS];
        end
        if (shift_r[TAG_HI-4]) begin
          pcm_in_r <= shift_r[S4_HI -: AC97_SLOT_BITS];
        end
      end else begin
        status_valid <= 1'b0;
        pcm_in_valid <= 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/ac97_link_frame.sv
// AC-link frame engine: serialises a per-frame snapshot of up to 12 output slots.
// Define AC97_LINK_RX_EN to compile in the codec input-frame deframer.
module ac97_link_frame
  import ac97_pkg::*;
#(
  parameter int NUM_OUT_SLOTS = 4
) (
  input  logic              ac97_bitclk,
  input  logic              rst,
  ac97_link_frame_if.slave  link,
  input  logic              ac97_sdata_in,
  output logic              ac97_sdata_out,
  output logic              ac97_sync,
  output logic              ac97_reset_b
);

  localparam int          DATA_W    = NUM_OUT_SLOTS * AC97_SLOT_BITS;
  localparam logic [7:0]  SYNC_LAST = 8'(AC97_SYNC_LEN - 1);

  logic [7:0]                 bit_q_r;
  logic [7:0]                 bit_next_s;
  logic                       shadow_en_r;
  logic [NUM_OUT_SLOTS-1:0]   shadow_valid_r;
  logic [DATA_W-1:0]          shadow_data_r;
  logic                       src_en_s;
  logic [NUM_OUT_SLOTS-1:0]   src_valid_s;
  logic [DATA_W-1:0]          src_data_s;
  logic [AC97_FRAME_BITS-1:0] frame_s;
  logic                       sdata_out_r;
  logic                       sync_r;
  logic                       strobe_r;
  logic                       reset_b_r;

  // Frame source: live inputs on the wrap edge (they become the snapshot), shadow otherwise.
  always_comb begin
    bit_next_s = bit_q_r + 8'd1;
    if (bit_q_r == 8'd255) begin
      src_en_s    = link.tx_en;
      src_valid_s = link.tx_slot_valid;
      src_data_s  = link.tx_slot_data;
    end else begin
      src_en_s    = shadow_en_r;
      src_valid_s = shadow_valid_r;
      src_data_s  = shadow_data_r;
    end
  end

  // Wire image of the frame indexed by bit_q: tag then slots MSB first, invalid slots zero.
  always_comb begin
    frame_s    = {AC97_FRAME_BITS{1'b0}};
    frame_s[0] = src_en_s & (|src_valid_s);
    for (int s = 1; s <= NUM_OUT_SLOTS; s++) begin
      frame_s[s] = src_en_s & src_valid_s[s-1];
      for (int i = 0; i < AC97_SLOT_BITS; i++) begin
        frame_s[slot_start(s) + i] = src_en_s & src_valid_s[s-1]
                                     & src_data_s[s*AC97_SLOT_BITS - 1 - i];
      end
    end
  end

  // Bit counter, snapshot and pin registers; the source mux makes the shadow hold mid-frame.
  always_ff @(posedge ac97_bitclk) begin
    if (rst) begin
      bit_q_r        <= 8'd254;
      shadow_en_r    <= 1'b0;
      shadow_valid_r <= {NUM_OUT_SLOTS{1'b0}};
      shadow_data_r  <= {DATA_W{1'b0}};
      sdata_out_r    <= 1'b0;
      sync_r         <= 1'b0;
      strobe_r       <= 1'b0;
      reset_b_r      <= 1'b0;
    end else begin
      bit_q_r        <= bit_next_s;
      shadow_en_r    <= src_en_s;
      shadow_valid_r <= src_valid_s;
      shadow_data_r  <= src_data_s;
      sdata_out_r    <= frame_s[bit_next_s];
      sync_r         <= (bit_next_s == 8'd255) || (bit_next_s < SYNC_LAST);
      strobe_r       <= (bit_next_s == 8'd255);
      reset_b_r      <= 1'b1;
    end
  end

  assign ac97_sdata_out   = sdata_out_r;
  assign ac97_sync        = sync_r;
  assign ac97_reset_b     = reset_b_r;
  assign link.ac97_strobe = strobe_r;

`ifdef AC97_LINK_RX_EN
  ac97_rx_deframer u_rx (
    .ac97_bitclk   (ac97_bitclk),
    .rst           (rst),
    .bit_q         (bit_q_r),
    .ac97_sdata_in (ac97_sdata_in),
    .codec_ready   (link.codec_ready),
    .status_addr   (link.status_addr),
    .status_data   (link.status_data),
    .status_valid  (link.status_valid),
    .rx_slotreq    (link.rx_slotreq),
    .pcm_in_l      (link.pcm_in_l),
    .pcm_in_r      (link.pcm_in_r),
    .pcm_in_valid  (link.pcm_in_valid)
  );
`else
  logic rx_unused_s;
  assign rx_unused_s       = ac97_sdata_in;
  assign link.codec_ready  = 1'b0;
  assign link.status_addr  = 7'd0;
  assign link.status_data  = 16'd0;
  assign link.status_valid = 1'b0;
  assign link.rx_slotreq   = 10'd0;
  assign link.pcm_in_l     = 20'd0;
  assign link.pcm_in_r     = 20'd0;
  assign link.pcm_in_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ac97_link_frame.sv
// Directed bench for ac97_link_frame: table of tx frames plus hand sequences for
// snapshot stability, rx decode (build dependent) and mid-frame reset.
module tb_ac97_link_frame;
  import ac97_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic sdata_in;
  logic sdo4, sync4, rb4, sdo2, sync2, rb2;
  int   checks = 0;
  int   errors = 0;

  logic [255:0] f4, f2, zero_f, rx_a, rx_b;
  int sync_err, sv_cnt, sv_bit, pv_cnt, pv_bit;

  always #5 clk = ~clk;

  ac97_link_frame_if #(.NUM_OUT_SLOTS(4)) link4 ();
  ac97_link_frame_if #(.NUM_OUT_SLOTS(2)) link2 ();

  ac97_link_frame #(.NUM_OUT_SLOTS(4)) dut4 (
    .ac97_bitclk(clk), .rst(rst), .link(link4), .ac97_sdata_in(sdata_in),
    .ac97_sdata_out(sdo4), .ac97_sync(sync4), .ac97_reset_b(rb4));

  ac97_link_frame #(.NUM_OUT_SLOTS(2)) dut2 (
    .ac97_bitclk(clk), .rst(rst), .link(link2), .ac97_sdata_in(sdata_in),
    .ac97_sdata_out(sdo2), .ac97_sync(sync2), .ac97_reset_b(rb2));

  typedef struct {
    logic        en;
    logic [3:0]  valid;
    logic [79:0] data;
    logic [15:0] exp_tag;
    logic [79:0] exp_slots;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slots 1..4 read back MSB-first from a wire-indexed frame, packed {s4,s3,s2,s1}.
  function automatic logic [79:0] slots_of(input logic [255:0] f);
    logic [79:0] r;
    r = 80'd0;
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 20; i++)
        r[s*20 + 19 - i] = f[16 + 20*s + i];
    return r;
  endfunction

  function automatic logic [255:0] build_rx(input logic [15:0] tag, input logic [79:0] w);
    logic [255:0] f;
    f = 256'd0;
    for (int p = 0; p < 16; p++) f[p] = tag[15-p];
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 20; i++)
        f[16 + 20*s + i] = w[s*20 + 19 - i];
    return f;
  endfunction

  // One full frame starting from the strobe cycle; records pins and rx pulses.
  task automatic run_frame(input logic [255:0] rxf, input int chg_bit,
                           input logic chg_en, input logic [79:0] chg_data);
    sync_err = 0; sv_cnt = 0; sv_bit = -1; pv_cnt = 0; pv_bit = -1;
    for (int b = 0; b < 256; b++) begin
      step();
      sdata_in = rxf[b];
      if (b == chg_bit) begin
        link4.tx_en        = chg_en;
        link4.tx_slot_data = chg_data;
      end
      f4[b] = sdo4;
      f2[b] = sdo2;
      if (sync4 !== ((b < 15) || (b == 255)) || link4.ac97_strobe !== (b == 255)
          || rb4 !== 1'b1 || sync2 !== sync4 || rb2 !== 1'b1) sync_err++;
      if (link4.status_valid === 1'b1) begin sv_cnt++; sv_bit = b; end
      if (link4.pcm_in_valid === 1'b1) begin pv_cnt++; pv_bit = b; end
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] tag, input logic [79:0] slots);
    check({name, "_tag"},   80'(f4[15:0]), 80'(tag));
    check({name, "_slots"}, slots_of(f4), slots);
    check({name, "_rest"},  80'(|f4[255:96]), 80'd0);
    check({name, "_sync"},  80'(sync_err), 80'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'b0100, {20'h44444, 20'hABCDE, 20'h22222, 20'h11111}, 16'h0009,
                {20'h00000, 20'hABCDE, 20'h00000, 20'h00000}};
    vecs[1] = '{1'b0, 4'b1111, {20'h44444, 20'hABCDE, 20'h22222, 20'h11111}, 16'h0000, 80'd0};
    vecs[2] = '{1'b1, 4'b1111, {20'h0F0F0, 20'hBCDEF, 20'h6789A, 20'h12345}, 16'h001F,
                {20'h0F0F0, 20'hBCDEF, 20'h6789A, 20'h12345}};
    vecs[3] = '{1'b1, 4'b0000, {20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF}, 16'h0000, 80'd0};
    vecs[4] = '{1'b1, 4'b1010, {20'h00001, 20'hFFFFF, 20'h80001, 20'hFFFFF}, 16'h0015,
                {20'h00001, 20'h00000, 20'h80001, 20'h00000}};
    zero_f = 256'd0;
    rx_a   = build_rx(16'hE000, {20'h0, 20'h0, 20'h000F0, 20'h26000});
    rx_b   = build_rx(16'h9800, {20'hABCDE, 20'h12345, 20'h0, 20'h00FFC});

    rst = 1'b1; sdata_in = 1'b0;
    link4.tx_en = 1'b0; link4.tx_slot_valid = 4'd0; link4.tx_slot_data = 80'd0;
    link2.tx_en = 1'b1; link2.tx_slot_valid = 2'b11;
    link2.tx_slot_data = {20'h5A5A5, 20'hC3C3C};

    // Reset release
    repeat (5) step();
    check("rst_outs", 80'({sdo4, sync4, link4.ac97_strobe, rb4, link4.codec_ready,
                           link4.status_valid, sdo2, rb2}), 80'd0);
    rst = 1'b0;
    step();
    check("rel_outs", 80'({sdo4, sync4, link4.ac97_strobe, rb4}), 80'(4'b0111));

    // Table-driven tx frames
    for (int v = 0; v < 5; v++) begin
      link4.tx_en         = vecs[v].en;
      link4.tx_slot_valid = vecs[v].valid;
      link4.tx_slot_data  = vecs[v].data;
      run_frame(zero_f, -1, 1'b0, 80'd0);
      check_frame($sformatf("v%0d", v), vecs[v].exp_tag, vecs[v].exp_slots);
      if (v == 0) begin
        check("n2_tag",   80'(f2[15:0]), 80'(16'h0007));
        check("n2_slots", slots_of(f2), {40'd0, 20'h5A5A5, 20'hC3C3C});
        check("n2_rest",  80'(|f2[255:56]), 80'd0);
      end
    end

    // Snapshot stability: data and tx_en changed mid-slot1 only show next frame
    link4.tx_en = 1'b1; link4.tx_slot_valid = 4'b0001; link4.tx_slot_data = {60'd0, 20'h13579};
    run_frame(zero_f, 20, 1'b0, {60'd0, 20'h2468A});
    check_frame("snap0", 16'h0003, {60'd0, 20'h13579});
    run_frame(zero_f, -1, 1'b0, 80'd0);
    check_frame("snap1", 16'h0000, 80'd0);
    link4.tx_en = 1'b1;
    run_frame(zero_f, -1, 1'b0, 80'd0);
    check_frame("snap2", 16'h0003, {60'd0, 20'h2468A});

    // Rx: status frame, then pcm frame, then an empty frame
    run_frame(rx_a, -1, 1'b0, 80'd0);
    run_frame(rx_b, -1, 1'b0, 80'd0);
`ifdef AC97_LINK_RX_EN
    check("st_cnt",   80'(sv_cnt), 80'd1);
    check("st_bit",   80'(sv_bit), 80'd1);
    check("st_pv",    80'(pv_cnt), 80'd0);
    check("st_ready", 80'(link4.codec_ready), 80'd1);
    check("st_addr",  80'(link4.status_addr), 80'h26);
    check("st_data",  80'(link4.status_data), 80'h000F);
`else
    check("st_cnt",   80'(sv_cnt), 80'd0);
    check("st_ready", 80'(link4.codec_ready), 80'd0);
    check("st_data",  80'(link4.status_data), 80'd0);
`endif
    run_frame(zero_f, -1, 1'b0, 80'd0);
`ifdef AC97_LINK_RX_EN
    check("pcm_cnt",  80'(pv_cnt), 80'd1);
    check("pcm_bit",  80'(pv_bit), 80'd1);
    check("pcm_sv",   80'(sv_cnt), 80'd0);
    check("pcm_l",    80'(link4.pcm_in_l), 80'h12345);
    check("pcm_r",    80'(link4.pcm_in_r), 80'hABCDE);
    check("pcm_req",  80'(link4.rx_slotreq), 80'h3FF);
    check("pcm_addr", 80'(link4.status_addr), 80'h26);
`else
    check("pcm_cnt",  80'(pv_cnt), 80'd0);
    check("pcm_l",    80'(link4.pcm_in_l), 80'd0);
`endif
    run_frame(zero_f, -1, 1'b0, 80'd0);
`ifdef AC97_LINK_RX_EN
    check("hold_ready", 80'(link4.codec_ready), 80'd0);
    check("hold_pcm",   80'(link4.pcm_in_l), 80'h12345);
`else
    check("hold_ready", 80'(link4.codec_ready), 80'd0);
`endif
    check("hold_pv", 80'(pv_cnt), 80'd0);

    // Mid-frame reset at bit 100
    link4.tx_en = vecs[2].en; link4.tx_slot_valid = vecs[2].valid;
    link4.tx_slot_data = vecs[2].data;
    for (int b = 0; b <= 100; b++) begin
      step();
      sdata_in = rx_a[b];
    end
    rst = 1'b1;
    step();
    check("mrst_outs", 80'({sdo4, sync4, link4.ac97_strobe, rb4, link4.status_valid}), 80'd0);
    sdata_in = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    step();
    check("mrst_rel", 80'({sdo4, sync4, link4.ac97_strobe, rb4}), 80'(4'b0111));
    run_frame(zero_f, -1, 1'b0, 80'd0);
    check_frame("mrst", vecs[2].exp_tag, vecs[2].exp_slots);
    check("mrst_sv", 80'(sv_cnt), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
